// File: rtl/riscy_cacheline_adapter.sv
// Bridges one 256-bit L2 line read/write to four 64-bit physical-memory beats.
// Latency: accept in T, beats from T+1, one-cycle line_resp_o after the last beat.
// Backpressure: memory paces each beat with burst_resp_i; L2 holds its request until line_resp_o.
module riscy_cacheline_adapter #(
  parameter int s_line  = 256,
  parameter int s_burst = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_read_i,
  input  logic               line_write_i,
  input  logic [31:0]        line_address_i,
  input  logic [s_line-1:0]  line_wdata_i,
  output logic [s_line-1:0]  line_rdata_o,
  output logic               line_resp_o,
  output logic               burst_read_o,
  output logic               burst_write_o,
  output logic [31:0]        burst_address_o,
  output logic [s_burst-1:0] burst_wdata_o,
  input  logic [s_burst-1:0] burst_rdata_i,
  input  logic               burst_resp_i
);

  localparam int s_beats = s_line / s_burst;
  localparam int cw      = $clog2(s_beats);
  localparam int ob      = $clog2(s_line / 8);
  localparam logic [31:0] addr_mask = ~((32'd1 << ob) - 32'd1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]        state;
  logic [cw-1:0]     cnt;
  logic [s_line-1:0] line_buf;
  logic [s_line-1:0] buf_nxt;
  logic              last_beat;

  assign last_beat = burst_resp_i && (cnt == cw'(s_beats - 1));

  // Read buffer with the current beat merged in, so the final beat can publish the whole line.
  always_comb begin
    buf_nxt = line_buf;
    buf_nxt[s_burst*cnt +: s_burst] = burst_rdata_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      cnt             <= '0;
      line_buf        <= '0;
      line_rdata_o    <= '0;
      burst_address_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (line_write_i) begin
            state           <= WRITE;
            cnt             <= '0;
            line_buf        <= line_wdata_i;
            burst_address_o <= line_address_i & addr_mask;
          end else if (line_read_i) begin
            state           <= READ;
            cnt             <= '0;
            burst_address_o <= line_address_i & addr_mask;
          end
        end
        READ: begin
          if (burst_resp_i) begin
            line_buf <= buf_nxt;
            cnt      <= cnt + cw'(1);
            if (last_beat) begin
              state        <= DONE;
              line_rdata_o <= buf_nxt;
            end
          end
        end
        WRITE: begin
          if (burst_resp_i) begin
            cnt <= cnt + cw'(1);
            if (last_beat) state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign line_resp_o   = (state == DONE);
  assign burst_read_o  = (state == READ);
  assign burst_write_o = (state == WRITE);
  assign burst_wdata_o = (state == WRITE) ? line_buf[s_burst*cnt +: s_burst] : '0;

endmodule

// File: doc/riscy_cacheline_adapter.md
Name: riscy_cacheline_adapter

Overview:
- Sits below the L2 cache. Acts as the responder for the L2's 256-bit line-side physical-memory interface (pmem_read/pmem_write/pmem_address/pmem_wdata/pmem_rdata/pmem_resp).
- Acts as the initiator toward physical memory, which moves data as 64-bit bursts.
- Converts one line read or write into a burst of s_line/s_burst beats, then returns a one-cycle response to the L2.

Parameters:
- s_line, 256: line width in bits.
- s_burst, 64: burst beat width in bits.
- s_beats, s_line/s_burst (4): beats per line; the counter is $clog2(s_beats) bits.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- line_read_i  in  1  line read request from L2, held until line_resp_o.
- line_write_i  in  1  line write request from L2, held until line_resp_o.
- line_address_i  in  32  line address from L2.
- line_wdata_i  in  s_line  write line from L2.
- line_rdata_o  out  s_line  assembled read line.
- line_resp_o  out  1  one-cycle completion pulse to L2.
- burst_read_o  out  1  read request to physical memory.
- burst_write_o  out  1  write request to physical memory.
- burst_address_o  out  32  line-aligned address to physical memory.
- burst_wdata_o  out  s_burst  current write beat.
- burst_rdata_i  in  s_burst  current read beat.
- burst_resp_i  in  1  beat-accept/beat-valid strobe from physical memory.

Behaviour:
- Reset:
  - State goes to IDLE and the beat counter goes to 0.
  - line_rdata_o, line_resp_o, burst_read_o, burst_write_o, burst_address_o and burst_wdata_o are all 0 from the cycle after rst is sampled high.
  - Reset mid-burst abandons the transfer. No line_resp_o is issued.
- IDLE:
  - Samples requests only in this state. line_write_i has priority when both requests are high.
  - On acceptance it latches burst_address_o = {line_address_i[31:5], 5'b0}.
  - A write also latches line_wdata_i into an internal line buffer.
  - Next state is WRITE or READ, and the counter is cleared.
  - burst_resp_i is ignored in IDLE.
- READ:
  - burst_read_o = 1 for the whole state.
  - Each cycle with burst_resp_i = 1 stores burst_rdata_i into the line buffer at bits [s_burst*cnt +: s_burst] and increments cnt.
  - Gaps (burst_resp_i = 0) are allowed and hold the state.
  - On the beat where cnt == s_beats-1, next state is DONE.
- WRITE:
  - burst_write_o = 1 for the whole state.
  - burst_wdata_o = line_buffer[s_burst*cnt +: s_burst], combinational from the current cnt.
  - Each burst_resp_i = 1 accepts the beat and increments cnt. The last beat moves to DONE.
- DONE:
  - Lasts exactly one cycle, with line_resp_o = 1 and burst_read_o = burst_write_o = 0. Next state is IDLE.
  - After a read, line_rdata_o = the assembled buffer.
  - line_rdata_o holds its value until the next read completes. A write never alters line_rdata_o.
- Latency:
  - A request accepted in cycle T with memory asserting burst_resp_i on every cycle from T+1 gives beats at T+1..T+4 and line_resp_o at T+5.
  - Minimum turnaround is 6 cycles from acceptance to the next possible acceptance (DONE at T+5, IDLE at T+6).
- Held inputs:
  - line_address_i and line_wdata_i changes after acceptance are ignored.
  - Because the L2 deasserts its request on seeing line_resp_o, the IDLE cycle after DONE never re-accepts the same request.
- Counter: wraps from s_beats-1 to 0 on the final beat.
- Beat order: beat k always maps to line bits [64k+63:64k], with k = 0 first.
- burst_address_o is constant for the whole transfer.

Test Plan:
- Read, back-to-back beats:
  - Stimulus: line_read_i=1, addr 0x1234_567F; memory returns beats 0x0..0x11, 0x..22, 0x..33, 0x..44 on consecutive cycles.
  - Required: burst_address_o=0x1234_5660; line_resp_o exactly 5 cycles after acceptance; line_rdata_o = {beat3,beat2,beat1,beat0}.
- Write:
  - Stimulus: line_write_i=1, line_wdata_i={64'hDDDD..,64'hCCCC..,64'hBBBB..,64'hAAAA..}.
  - Required: burst_wdata_o = AAAA, BBBB, CCCC, DDDD on successive burst_resp_i cycles; burst_write_o drops and line_resp_o pulses once.
  - Required: line_rdata_o is unchanged from the prior read.
- Stalled beats: read with burst_resp_i gaps of 0, 2 and 3 cycles between beats -> counter holds during gaps, correct assembled line, single line_resp_o.
- Simultaneous requests: line_read_i=line_write_i=1 -> burst_write_o=1, burst_read_o stays 0, write beats are emitted.
- Reset mid-read: rst asserted after beat 2 -> the next cycle has all outputs 0 and no line_resp_o; a fresh read afterwards completes normally with 4 new beats.
- Noise in IDLE: burst_resp_i pulsed with no request pending -> no state change and no line_resp_o.
